// File: rtl/alu_next_pc.sv
// Execute-and-next-PC block: 32-bit ALU, branch mux, jump mux and a sticky signed-overflow flag.
// Optional feature macro ALU_EXT_OPS_EN adds codes 100 (a AND NOT b) and 101 (a OR NOT b).
module alu_next_pc (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  alu_control,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic        ovf_sticky,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] pc_branch,
    input  logic        pc_src,
    output logic [31:0] branch_pc,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] pc_next
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] sum_s;
    logic signed [31:0] diff_s;
    logic               ovf;

    // Two's-complement overflow, judged from operand and result signs.
    function automatic logic add_ovf(input logic signed [31:0] a, input logic signed [31:0] b,
                                     input logic signed [31:0] r);
        return (a[31] == b[31]) && (r[31] != a[31]);
    endfunction

    function automatic logic sub_ovf(input logic signed [31:0] a, input logic signed [31:0] b,
                                     input logic signed [31:0] r);
        return (a[31] != b[31]) && (r[31] != a[31]);
    endfunction

    assign a_s    = src_a;
    assign b_s    = src_b;
    assign sum_s  = a_s + b_s;
    assign diff_s = a_s - b_s;

    always_comb begin
        alu_out = 32'd0;
        ovf     = 1'b0;
        case (alu_control)
            3'b000: alu_out = src_a & src_b;
            3'b001: alu_out = src_a | src_b;
            3'b010: begin
                alu_out = sum_s;
                ovf     = add_ovf(a_s, b_s, sum_s);
            end
            3'b110: begin
                alu_out = diff_s;
                ovf     = sub_ovf(a_s, b_s, diff_s);
            end
            // Direct signed compare stays correct when a - b would overflow.
            3'b111: alu_out = (a_s < b_s) ? 32'd1 : 32'd0;
`ifdef ALU_EXT_OPS_EN
            3'b100: alu_out = src_a & ~src_b;
            3'b101: alu_out = src_a | ~src_b;
`endif
            default: alu_out = 32'd0;
        endcase
    end

    assign zero = (alu_out == 32'd0);

    // Jump outranks branch; the jump target keeps the upper nibble of the branch-mux result.
    assign branch_pc = pc_src ? pc_branch : pc_plus4;
    assign pc_next   = jump ? {branch_pc[31:28], jump_index, 2'b00} : branch_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else if (ovf) begin
            ovf_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_next_pc.sv
// Self-checking bench for alu_next_pc: directed plan cases plus randomized ops against an arithmetic model.
module tb_alu_next_pc;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  alu_control = 3'b000;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [31:0] alu_out;
    logic        zero;
    logic        ovf_sticky;
    logic [31:0] pc_plus4 = '0;
    logic [31:0] pc_branch = '0;
    logic        pc_src = 1'b0;
    logic [31:0] branch_pc;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic [31:0] pc_next;

    int n_checks = 0;
    int n_fails  = 0;
    logic exp_sticky = 1'b0;

    alu_next_pc dut (
        .clock(clock), .reset(reset), .alu_control(alu_control),
        .src_a(src_a), .src_b(src_b), .alu_out(alu_out), .zero(zero),
        .ovf_sticky(ovf_sticky), .pc_plus4(pc_plus4), .pc_branch(pc_branch),
        .pc_src(pc_src), .branch_pc(branch_pc), .jump(jump),
        .jump_index(jump_index), .pc_next(pc_next)
    );

    always #5 clock = ~clock;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference ALU: exact 64-bit integer arithmetic, overflow = result outside the 32-bit signed range.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov);
        longint sa, sb, s;
        longint max_i, min_i;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        max_i = 64'sd2147483647;
        min_i = -longint'(32'h8000_0000);
        s     = 0;
        r     = 32'd0;
        ov    = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s  = sa + sb;
                r  = s[31:0];
                ov = (s > max_i) || (s < min_i);
            end
            3'b110: begin
                s  = sa - sb;
                r  = s[31:0];
                ov = (s > max_i) || (s < min_i);
            end
            3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_EXT_OPS_EN
            3'b100: r = a & ~b;
            3'b101: r = a | ~b;
`endif
            default: r = 32'd0;
        endcase
    endfunction

    task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rst);
        logic [31:0] er;
        logic        eo;
        @(negedge clock);
        alu_control = op;
        src_a       = a;
        src_b       = b;
        reset       = rst;
        #1;
        model(op, a, b, er, eo);
        check32("alu_out", alu_out, er);
        check1("zero", zero, er == 32'd0);
        @(posedge clock);
        if (rst) exp_sticky = 1'b0;
        else if (eo) exp_sticky = 1'b1;
        #1;
        check1("ovf_sticky", ovf_sticky, exp_sticky);
    endtask

    task automatic pc_step(input logic [31:0] p4, input logic [31:0] pb, input logic ps,
                           input logic jmp, input logic [25:0] idx);
        logic [31:0] eb, en;
        pc_plus4   = p4;
        pc_branch  = pb;
        pc_src     = ps;
        jump       = jmp;
        jump_index = idx;
        #1;
        eb = ps ? pb : p4;
        en = jmp ? ((eb & 32'hF000_0000) + 32'(idx) * 4) : eb;
        check32("branch_pc", branch_pc, eb);
        check32("pc_next", pc_next, en);
    endtask

    initial begin
        // Reset state
        step(3'b000, 32'd0, 32'd0, 1'b1);
        check1("reset_value", ovf_sticky, 1'b0);

        // Overflowing add, then flag must hold through benign ops
        step(3'b010, 32'h7FFF_FFFF, 32'd1, 1'b0);
        check32("add_ovf_result", alu_out, 32'h8000_0000);
        check1("sticky_set", ovf_sticky, 1'b1);
        step(3'b000, 32'h1234_5678, 32'hFFFF_0000, 1'b0);
        step(3'b010, 32'd3, 32'd4, 1'b0);
        check1("sticky_hold", ovf_sticky, 1'b1);

        // Sub / slt
        step(3'b110, 32'd5, 32'd5, 1'b0);
        check1("sub_zero", zero, 1'b1);
        step(3'b111, 32'hFFFF_FFFF, 32'd1, 1'b0);
        step(3'b111, 32'h8000_0000, 32'd1, 1'b0);
        check32("slt_min", alu_out, 32'd1);
        step(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);

        // Logic ops and null / extended codes
        step(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        check32("and_const", alu_out, 32'h00F0_00F0);
        step(3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        check32("or_const", alu_out, 32'hFFF0_FFF0);
        step(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step(3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        step(3'b101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);

        // Reset wins over a simultaneous overflow; release with a benign op
        step(3'b010, 32'h7FFF_FFFF, 32'd1, 1'b1);
        check1("reset_beats_ovf", ovf_sticky, 1'b0);
        step(3'b010, 32'd1, 32'd1, 1'b0);
        check1("after_reset", ovf_sticky, 1'b0);
        step(3'b110, 32'h8000_0000, 32'd1, 1'b0);
        check1("sub_ovf_set", ovf_sticky, 1'b1);

        // Branch and jump muxes
        pc_step(32'h0040_0008, 32'h0040_0020, 1'b0, 1'b0, 26'd0);
        check32("branch_not_taken", pc_next, 32'h0040_0008);
        pc_step(32'h0040_0008, 32'h0040_0020, 1'b1, 1'b0, 26'd0);
        check32("branch_taken", pc_next, 32'h0040_0020);
        pc_step(32'h1000_0004, 32'h0040_0020, 1'b0, 1'b1, 26'h000_0010);
        check32("jump", pc_next, 32'h1000_0040);
        pc_step(32'h1000_0004, 32'h2000_0000, 1'b1, 1'b1, 26'h000_0010);
        check32("jump_priority", pc_next, 32'h2000_0040);

        // Randomized ops with edge-value operands and occasional reset
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            logic [2:0]  op;
            case ($urandom_range(0, 3))
                0: a = 32'h7FFF_FFFF;
                1: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: b = 32'h8000_0000;
                1: b = a;
                default: b = $urandom;
            endcase
            op = 3'($urandom_range(0, 7));
            step(op, a, b, ($urandom_range(0, 15) == 0));
            pc_step($urandom, $urandom, 1'($urandom), 1'($urandom), 26'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
